sr_flag_scheduler: RTL and testbench

//  Shares a bank of NFLAG set/reset flag flip-flops between NREQ requesters.

---
 rtl/sr_flag_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_sr_flag_scheduler.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_flag_scheduler.sv
// sr_flag_scheduler: round-robin arbitrated set/clear of a shared flag bank with sweep clear.
// Optional requester lock (HOLD state) enabled by defining SR_FLAG_SCHED_LOCK_EN.
module sr_flag_scheduler #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 rNot,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      op,
  input  logic [NREQ*IDXW-1:0] idx,
  input  logic                 clrAll,
`ifdef SR_FLAG_SCHED_LOCK_EN
  input  logic [NREQ-1:0]      lock,
`endif
  output logic [NREQ-1:0]      gnt,
  output logic                 err,
  output logic                 busy,
  output logic [NFLAG-1:0]     q,
  output logic [NFLAG-1:0]     qNot
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

`ifdef SR_FLAG_SCHED_LOCK_EN
  typedef enum logic [1:0] {
    IDLE, GRANT, SWEEP, HOLD
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE, GRANT, SWEEP
  } state_t;
`endif

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [IDXW-1:0] cnt_q, cnt_d;
  logic            pend_q, pend_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [NFLAG-1:0] q_q, q_d;
`ifdef SR_FLAG_SCHED_LOCK_EN
  logic [PW-1:0]   own_q, own_d;
`endif

  logic            found;
  logic [PW-1:0]   win;
  logic [PW-1:0]   sel;
  logic [IDXW-1:0] sel_idx;
  logic            sel_op;
  logic            do_op;

  // first asserted request scanning from ptr upward, wrapping
  always_comb begin
    int k;
    found = 1'b0;
    win   = '0;
    k     = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = (int'(ptr_q) + i) % NREQ;
      if (!found && req[k]) begin
        found = 1'b1;
        win   = PW'(k);
      end
    end
  end

`ifdef SR_FLAG_SCHED_LOCK_EN
  assign sel = (state_q == HOLD) ? own_q : win;
`else
  assign sel = win;
`endif

  assign sel_idx = idx[int'(sel)*IDXW +: IDXW];
  assign sel_op  = op[sel];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    gnt_d   = '0;
    err_d   = 1'b0;
    q_d     = q_q;
    do_op   = 1'b0;
`ifdef SR_FLAG_SCHED_LOCK_EN
    own_d   = own_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (clrAll || pend_q) begin
          state_d = SWEEP;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (found) begin
          do_op   = 1'b1;
          state_d = GRANT;
          ptr_d   = (int'(win) == NREQ-1) ? '0 : win + 1'b1;
`ifdef SR_FLAG_SCHED_LOCK_EN
          own_d   = win;
`endif
        end
      end
      GRANT: begin
        pend_d  = pend_q | clrAll;
        state_d = IDLE;
`ifdef SR_FLAG_SCHED_LOCK_EN
        if (lock[own_q]) state_d = HOLD;
`endif
      end
      SWEEP: begin
        for (int f = 0; f < NFLAG; f++)
          if (int'(cnt_q) == f) q_d[f] = 1'b0;
        cnt_d = cnt_q + 1'b1;
        if (int'(cnt_q) == NFLAG-1) state_d = IDLE;
      end
`ifdef SR_FLAG_SCHED_LOCK_EN
      HOLD: begin
        pend_d = pend_q | clrAll;
        if (!lock[own_q]) begin
          state_d = IDLE;
        end else if (req[own_q]) begin
          do_op   = 1'b1;
          state_d = GRANT;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // out-of-range index still consumes the grant but leaves the bank alone
    if (do_op) begin
      gnt_d[sel] = 1'b1;
      if (int'(sel_idx) >= NFLAG) begin
        err_d = 1'b1;
      end else begin
        for (int f = 0; f < NFLAG; f++)
          if (int'(sel_idx) == f) q_d[f] = sel_op;
      end
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rNot) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      gnt_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      q_q     <= '0;
`ifdef SR_FLAG_SCHED_LOCK_EN
      own_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      gnt_q   <= gnt_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      q_q     <= q_d;
`ifdef SR_FLAG_SCHED_LOCK_EN
      own_q   <= own_d;
`endif
    end
  end

  assign gnt  = gnt_q;
  assign err  = err_q;
  assign busy = busy_q;
  assign q    = q_q;
  assign qNot = ~q_q;

endmodule

// File: tb/tb_sr_flag_scheduler.sv
// tb_sr_flag_scheduler: directed checks of arbitration, set/clear, error, sweep and reset.
// Lock scenario compiled in when SR_FLAG_SCHED_LOCK_EN is defined.
module tb_sr_flag_scheduler;

  logic        clk = 1'b0;
  logic        rNot;
  logic [3:0]  req;
  logic [3:0]  op;
  logic [11:0] idx;
  logic        clrAll;
`ifdef SR_FLAG_SCHED_LOCK_EN
  logic [3:0]  lock;
`endif
  logic [3:0]  gnt, gnt6;
  logic        err, err6;
  logic        busy, busy6;
  logic [7:0]  q, qNot;
  logic [5:0]  q6, qNot6;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sr_flag_scheduler u_dut (
    .clk(clk), .rNot(rNot), .req(req), .op(op), .idx(idx),
    .clrAll(clrAll),
`ifdef SR_FLAG_SCHED_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt), .err(err), .busy(busy), .q(q), .qNot(qNot)
  );

  sr_flag_scheduler #(.NREQ(4), .NFLAG(6), .IDXW(3)) u_dut6 (
    .clk(clk), .rNot(rNot), .req(req), .op(op), .idx(idx),
    .clrAll(clrAll),
`ifdef SR_FLAG_SCHED_LOCK_EN
    .lock(lock),
`endif
    .gnt(gnt6), .err(err6), .busy(busy6), .q(q6), .qNot(qNot6)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rNot = 1'b0;
    tick();
    rNot = 1'b1;
  endtask

  task automatic test_reset();
    req = 4'b0001; op = 4'b0001; idx = 12'd5;
    tick();
    req = 4'b0000;
    rNot = 1'b0;
    tick();
    total++;
    if (q !== 8'h00) begin bad++; $display("FAIL reset_q got=%h exp=00", q); end
    total++;
    if (qNot !== 8'hFF) begin bad++; $display("FAIL reset_qnot got=%h exp=ff", qNot); end
    total++;
    if (gnt !== 4'b0000 || err !== 1'b0) begin
      bad++; $display("FAIL reset_gnt got=%b/%b exp=0000/0", gnt, err);
    end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    rNot = 1'b1;
  endtask

  task automatic test_single_set();
    do_reset();
    req = 4'b0001; op = 4'b0001; idx = {3'd0, 3'd0, 3'd0, 3'd5};
    tick();
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
    total++;
    if (q !== 8'h20 || qNot !== 8'hDF) begin
      bad++; $display("FAIL single_q got=%h/%h exp=20/df", q, qNot);
    end
    total++;
    if (busy !== 1'b1 || err !== 1'b0) begin
      bad++; $display("FAIL single_busy got=%b/%b exp=1/0", busy, err);
    end
    req = 4'b0000;
    tick();
    total++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL single_drop got=%b/%b exp=0000/0", gnt, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    do_reset();
    req = 4'b1111; op = 4'b1111; idx = {3'd3, 3'd2, 3'd1, 3'd0};
    for (int k = 0; k < 4; k++) begin
      exp_g = 4'b0001 << k;
      tick();
      total++;
      if (gnt !== exp_g) begin bad++; $display("FAIL rr_gnt%0d got=%b exp=%b", k, gnt, exp_g); end
      req[k] = 1'b0;
      tick();
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL rr_gap%0d got=%b exp=0000", k, gnt); end
    end
    total++;
    if (q !== 8'h0F) begin bad++; $display("FAIL rr_q got=%h exp=0f", q); end
    req = 4'b0011; op = 4'b0000;
    tick();
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL rr2_first got=%b exp=0001", gnt); end
    req[0] = 1'b0;
    tick();
    tick();
    total++;
    if (gnt !== 4'b0010) begin bad++; $display("FAIL rr2_second got=%b exp=0010", gnt); end
    req = 4'b0000;
    tick();
    total++;
    if (q !== 8'h0C) begin bad++; $display("FAIL rr2_q got=%h exp=0c", q); end
  endtask

  task automatic test_out_of_range();
    do_reset();
    req = 4'b0001; op = 4'b0001; idx = {3'd0, 3'd0, 3'd0, 3'd2};
    tick();
    total++;
    if (q6 !== 6'h04 || err6 !== 1'b0) begin
      bad++; $display("FAIL oor_setup got=%h/%b exp=04/0", q6, err6);
    end
    req = 4'b0000;
    tick();
    req = 4'b0010; op = 4'b0010; idx = {3'd0, 3'd0, 3'd7, 3'd0};
    tick();
    total++;
    if (gnt6 !== 4'b0010 || err6 !== 1'b1) begin
      bad++; $display("FAIL oor_err got=%b/%b exp=0010/1", gnt6, err6);
    end
    total++;
    if (q6 !== 6'h04) begin bad++; $display("FAIL oor_q got=%h exp=04", q6); end
    total++;
    if (err !== 1'b0 || q !== 8'h84) begin
      bad++; $display("FAIL edge_idx7 got=%b/%h exp=0/84", err, q);
    end
    req = 4'b0000;
    tick();
    total++;
    if (err6 !== 1'b0 || gnt6 !== 4'b0000) begin
      bad++; $display("FAIL oor_drop got=%b/%b exp=0/0000", err6, gnt6);
    end
  endtask

  task automatic test_sweep();
    logic [7:0] exp_q;
    do_reset();
    op = 4'b0001;
    for (int f = 0; f < 8; f++) begin
      req = 4'b0001; idx = {3'd0, 3'd0, 3'd0, 3'(f)};
      tick();
      req = 4'b0000;
      tick();
    end
    total++;
    if (q !== 8'hFF) begin bad++; $display("FAIL sweep_fill got=%h exp=ff", q); end
    clrAll = 1'b1; req = 4'b0100; op = 4'b0100; idx = {3'd0, 3'd3, 3'd0, 3'd0};
    tick();
    clrAll = 1'b0;
    total++;
    if (busy !== 1'b1 || gnt !== 4'b0000 || q !== 8'hFF) begin
      bad++; $display("FAIL sweep_start got=%b/%b/%h exp=1/0000/ff", busy, gnt, q);
    end
    for (int i = 0; i < 8; i++) begin
      exp_q = 8'hFF << (i + 1);
      tick();
      total++;
      if (q !== exp_q || gnt !== 4'b0000 || busy !== (i < 7)) begin
        bad++;
        $display("FAIL sweep_step%0d got=%h/%b/%b exp=%h/0000/%b", i, q, gnt, busy, exp_q, i < 7);
      end
    end
    tick();
    total++;
    if (gnt !== 4'b0100 || q !== 8'h08) begin
      bad++; $display("FAIL sweep_after got=%b/%h exp=0100/08", gnt, q);
    end
    req = 4'b0000;
    tick();
    clrAll = 1'b1;
    tick();
    clrAll = 1'b0;
    tick();
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL sweep_mid got=%b exp=1", busy); end
    rNot = 1'b0;
    tick();
    rNot = 1'b1;
    total++;
    if (busy !== 1'b0 || q !== 8'h00) begin
      bad++; $display("FAIL sweep_abort got=%b/%h exp=0/00", busy, q);
    end
    tick();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL sweep_no_resume got=%b exp=0", busy); end
  endtask

  task automatic test_pending_clr();
    do_reset();
    req = 4'b0001; op = 4'b0001; idx = {3'd0, 3'd0, 3'd0, 3'd1};
    tick();
    req = 4'b0000; clrAll = 1'b1;
    tick();
    clrAll = 1'b0;
    total++;
    if (busy !== 1'b0 || q !== 8'h02) begin
      bad++; $display("FAIL pend_idle got=%b/%h exp=0/02", busy, q);
    end
    tick();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL pend_sweep got=%b exp=1", busy); end
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (busy !== 1'b0 || q !== 8'h00) begin
      bad++; $display("FAIL pend_done got=%b/%h exp=0/00", busy, q);
    end
  endtask

`ifdef SR_FLAG_SCHED_LOCK_EN
  task automatic test_lock();
    int n2;
    n2 = 0;
    do_reset();
    lock = 4'b0100; req = 4'b0100; op = 4'b0100; idx = {3'd0, 3'd1, 3'd0, 3'd0};
    tick();
    if (gnt === 4'b0100) n2++;
    for (int r = 0; r < 2; r++) begin
      req = 4'b0001;
      tick();
      total++;
      if (gnt !== 4'b0000) begin bad++; $display("FAIL lock_hold%0d got=%b exp=0000", r, gnt); end
      req = 4'b0101; idx[8 +: 3] = 3'(r + 2);
      tick();
      if (gnt === 4'b0100) n2++;
    end
    req = 4'b0001;
    tick();
    total++;
    if (n2 !== 3 || q !== 8'h0E) begin
      bad++; $display("FAIL lock_owner got=%0d/%h exp=3/0e", n2, q);
    end
    lock = 4'b0000;
    tick();
    total++;
    if (gnt !== 4'b0000) begin bad++; $display("FAIL lock_release got=%b exp=0000", gnt); end
    tick();
    total++;
    if (gnt !== 4'b0001) begin bad++; $display("FAIL lock_other got=%b exp=0001", gnt); end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rNot = 1'b0; req = '0; op = '0; idx = '0; clrAll = 1'b0;
`ifdef SR_FLAG_SCHED_LOCK_EN
    lock = '0;
`endif
    tick();
    rNot = 1'b1;
    test_reset();
    test_single_set();
    test_round_robin();
    test_out_of_range();
    test_sweep();
    test_pending_clr();
`ifdef SR_FLAG_SCHED_LOCK_EN
    test_lock();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
